// File: rtl/mem_responder_if.sv
// Memory bus between an initiator (master) and mem_responder (slave).
interface mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output read, write, addr, data_in,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  read, write, addr, data_in,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port memory responder: one read or write per clock, sequential
// zero-fill after reset, sticky protocol-error flags and saturating counters.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH     = 5,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    output logic                 err_collision,
    output logic                 err_busy,
    output logic [CNT_WIDTH-1:0] wr_count,
    output logic [CNT_WIDTH-1:0] rd_count
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

    state_e                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q,  clr_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_col_q,  err_col_d;
    logic                  err_busy_q, err_busy_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q,   wr_cnt_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q,   rd_cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        data_out_d = data_out_q;
        rd_valid_d = 1'b0;
        err_col_d  = err_col_q;
        err_busy_d = err_busy_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = bus.addr;
        mem_wdata  = bus.data_in;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
                if (bus.read || bus.write) begin
                    err_busy_d = 1'b1;
                end
            end
            ST_IDLE: begin
                unique case ({bus.read, bus.write})
                    2'b01: begin
                        mem_we   = 1'b1;
                        wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + 1'b1;
                    end
                    2'b10: begin
                        data_out_d = mem_q[bus.addr];
                        rd_valid_d = 1'b1;
                        rd_cnt_d   = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + 1'b1;
                    end
                    2'b11: begin
                        err_col_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_ptr_q  <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            err_col_q  <= 1'b0;
            err_busy_q <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
            err_col_q  <= err_col_d;
            err_busy_q <= err_busy_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Array has no reset; a reset edge suppresses whatever write was pending.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = (state_q == ST_CLEAR);
    assign err_collision  = err_col_q;
    assign err_busy       = err_busy_q;
    assign wr_count       = wr_cnt_q;
    assign rd_count       = rd_cnt_q;
endmodule
